bus_timer: RTL and testbench

Memory-mapped countdown timer on the CPU data bus. It decodes the core's data-bus address, byte enables, write data and write strobe, and returns combinational read data in the same cycle for the M-stage load path. It raises an interrupt request that the SoC wires into one bit of the core's `HWInt[5:0]`. Two instances typically occupy adjacent 16-byte windows.

---
 rtl/bus_timer_if.sv | 12 +
 rtl/bus_timer.sv | 129 ++++++++++++
 tb/tb_bus_timer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_timer_if.sv
// Data-bus port bundle between the core's M-stage memory path and bus_timer.
// The master drives address, strobe, byte enables and store data; the slave returns combinational read data.
interface bus_timer_if;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, we, byteen, wdata, input rdata);
    modport slave  (input addr, we, byteen, wdata, output rdata);
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and an interrupt request.
// Define BUS_TIMER_AUTORELOAD_EN to compile the auto-reload mode (MODE = 01).
module bus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    bus_timer_if.slave  bus,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    state_t      state, state_next;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        int_pend;

    logic        sel, ctrl_wr, preset_wr, auto_reload;
    logic        do_load, do_dec, do_zero, set_pend, clr_pend, clr_en;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^bus.addr[1:0];

    assign sel       = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign ctrl_wr   = sel && bus.we && (bus.addr[3:2] == OFF_CTRL) && (|bus.byteen);
    assign preset_wr = sel && bus.we && (bus.addr[3:2] == OFF_PRESET);

`ifdef BUS_TIMER_AUTORELOAD_EN
    assign auto_reload = (ctrl[2:1] == 2'b01);
`else
    assign auto_reload = 1'b0;
`endif

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) result[8*i +: 8] = new_val[8*i +: 8];
        end
        return result;
    endfunction

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_dec     = 1'b0;
        do_zero    = 1'b0;
        set_pend   = 1'b0;
        clr_pend   = 1'b0;
        clr_en     = 1'b0;
        unique case (state)
            IDLE: if (ctrl[0]) state_next = LOAD;
            LOAD: begin
                do_load    = 1'b1;
                state_next = CNT;
            end
            CNT: begin
                if (!ctrl[0]) begin
                    state_next = IDLE;
                end else if (count > 32'd1) begin
                    do_dec = 1'b1;
                end else begin
                    do_zero    = 1'b1;
                    set_pend   = 1'b1;
                    state_next = INT;
                end
            end
            INT: begin
                // A disabled timer never reloads, even in auto-reload mode.
                if (auto_reload && ctrl[0]) begin
                    clr_pend   = 1'b1;
                    state_next = LOAD;
                end else begin
                    clr_pend   = auto_reload;
                    clr_en     = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            int_pend <= 1'b0;
        end else begin
            state <= state_next;

            // A CTRL byte-0 write overrides the FSM's EN clear on the same edge.
            if (ctrl_wr && bus.byteen[0]) ctrl <= bus.wdata[3:0];
            else if (clr_en)              ctrl[0] <= 1'b0;

            if (preset_wr) preset <= merge_bytes(preset, bus.wdata, bus.byteen);

            if (do_load)      count <= preset;
            else if (do_dec)  count <= count - 32'd1;
            else if (do_zero) count <= 32'd0;

            if (set_pend)                                  int_pend <= 1'b1;
            else if (clr_pend || (ctrl_wr && !auto_reload)) int_pend <= 1'b0;
        end
    end

    always_comb begin
        bus.rdata = 32'd0;
        if (sel) begin
            case (bus.addr[3:2])
                OFF_CTRL:   bus.rdata = {28'd0, ctrl};
                OFF_PRESET: bus.rdata = preset;
                OFF_COUNT:  bus.rdata = count;
                default:    bus.rdata = 32'd0;
            endcase
        end
    end

    assign irq = int_pend & ctrl[3];
endmodule

// File: tb/tb_bus_timer.sv
// Scoreboard-driven bench for bus_timer: expected values are queued when stimulus is applied
// and popped when the corresponding read data or irq level is observed.
module tb_bus_timer;
    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic irq;

    bus_timer_if bus ();

    bus_timer #(.BASE_ADDR(BASE)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] exp;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.addr   = a;
        bus.we     = 1'b1;
        bus.byteen = be;
        bus.wdata  = d;
        @(posedge clk);
        #1;
        bus.we     = 1'b0;
        bus.byteen = 4'd0;
        bus.wdata  = 32'd0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.we   = 1'b0;
        #1;
        d = bus.rdata;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bus.we     = 1'b0;
        bus.byteen = 4'd0;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'd0);
        for (int i = 0; i < 4; i++) begin
            bus_rd(BASE + 32'(4 * i), got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_read off=%0h: got %h want %h", 4 * i, got, exp);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b want 0", irq);
        end
    endtask

    task automatic test_oneshot();
        int rise;
        bus_wr(BASE + 32'h4, 32'd5, 4'hF);
        bus_wr(BASE + 32'h0, 32'h9, 4'h1);
        exp_q.push_back(32'd7);
        rise = 0;
        for (int k = 1; k <= 40 && rise == 0; k++) begin
            tick(1);
            if (irq === 1'b1) rise = k;
        end
        exp = exp_q.pop_front();
        checks++;
        if (32'(rise) !== exp) begin
            errors++;
            $display("FAIL oneshot_irq_rise: got edge %0d want %0d", rise, exp);
        end
        tick(1);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h8);
        bus_rd(BASE + 32'h8, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL oneshot_count: got %h want %h", got, exp);
        end
        bus_rd(BASE + 32'h0, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL oneshot_ctrl: got %h want %h", got, exp);
        end
        tick(3);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_irq_hold: got %b want 1", irq);
        end
        bus_wr(BASE + 32'h0, 32'h8, 4'h1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_irq_clear: got %b want 0", irq);
        end
    endtask

    task automatic test_small_preset();
        for (int n = 0; n < 2; n++) begin
            int rise;
            do_reset();
            bus_wr(BASE + 32'h4, 32'(n), 4'hF);
            bus_wr(BASE + 32'h0, 32'h9, 4'h1);
            exp_q.push_back(32'd3);
            rise = 0;
            for (int k = 1; k <= 20 && rise == 0; k++) begin
                tick(1);
                if (irq === 1'b1) rise = k;
            end
            exp = exp_q.pop_front();
            checks++;
            if (32'(rise) !== exp) begin
                errors++;
                $display("FAIL small_preset_%0d_rise: got edge %0d want %0d", n, rise, exp);
            end
        end
    endtask

    task automatic test_autoreload();
        do_reset();
        bus_wr(BASE + 32'h4, 32'd3, 4'hF);
        bus_wr(BASE + 32'h0, 32'hB, 4'h1);
        for (int k = 1; k <= 21; k++) begin
`ifdef BUS_TIMER_AUTORELOAD_EN
            exp_q.push_back((k >= 5 && (k - 5) % 5 == 0) ? 32'd1 : 32'd0);
`else
            exp_q.push_back((k >= 5) ? 32'd1 : 32'd0);
`endif
            tick(1);
            exp = exp_q.pop_front();
            checks++;
            if ({31'd0, irq} !== exp) begin
                errors++;
                $display("FAIL autoreload_irq edge %0d: got %b want %0d", k, irq, exp);
            end
        end
`ifdef BUS_TIMER_AUTORELOAD_EN
        exp_q.push_back(32'hB);
`else
        exp_q.push_back(32'hA);
`endif
        bus_rd(BASE + 32'h0, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL autoreload_ctrl: got %h want %h", got, exp);
        end
    endtask

    task automatic test_stop();
        bit found;
        do_reset();
        bus_wr(BASE + 32'h4, 32'd100, 4'hF);
        bus_wr(BASE + 32'h0, 32'h9, 4'h1);
        found = 1'b0;
        for (int k = 1; k <= 200 && !found; k++) begin
            tick(1);
            bus_rd(BASE + 32'h8, got);
            if (got == 32'd40) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL stop_reach_40: got %h want 00000028 within bound", got);
        end
        bus_wr(BASE + 32'h0, 32'h8, 4'h1);
        tick(3);
        exp_q.push_back(32'd39);
        exp_q.push_back(32'd39);
        bus_rd(BASE + 32'h8, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL stop_count: got %h want %h", got, exp);
        end
        tick(5);
        bus_rd(BASE + 32'h8, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL stop_count_hold: got %h want %h", got, exp);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL stop_irq: got %b want 0", irq);
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] addrs[6];
        addrs = '{BASE + 32'h4, BASE + 32'h8, BASE + 32'hC,
                  BASE + 32'h0, BASE + 32'h10, BASE + 32'h14};
        bus_wr(BASE + 32'h4, 32'h1234_5678, 4'hF);
        bus_wr(BASE + 32'h4, 32'hAAAA_AAAA, 4'b0010);
        bus_wr(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
        bus_wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
        bus_wr(BASE + 32'h10, 32'h0000_000F, 4'hF);
        bus_wr(BASE + 32'h14, 32'hFFFF_FFFF, 4'hF);
        exp_q.push_back(32'h1234_AA78);
        exp_q.push_back(32'd39);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) tick(1);
            bus_rd(addrs[i], got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL byte_write addr=%h: got %h want %h", addrs[i], got, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus_wr(BASE + 32'h4, 32'd20, 4'hF);
        bus_wr(BASE + 32'h0, 32'h9, 4'h1);
        tick(5);
        bus.addr   = BASE + 32'h4;
        bus.we     = 1'b1;
        bus.byteen = 4'hF;
        bus.wdata  = 32'hFFFF_FFFF;
        reset      = 1'b1;
        tick(1);
        reset      = 1'b0;
        bus.we     = 1'b0;
        bus.byteen = 4'd0;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'd0);
        for (int i = 0; i < 4; i++) begin
            bus_rd(BASE + 32'(4 * i), got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid off=%0h: got %h want %h", 4 * i, got, exp);
            end
        end
        tick(30);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_irq: got %b want 0", irq);
        end
    endtask

    initial begin
        bus.addr   = 32'd0;
        bus.we     = 1'b0;
        bus.byteen = 4'd0;
        bus.wdata  = 32'd0;
        tick(2);
        test_reset();
        test_oneshot();
        test_small_preset();
        test_autoreload();
        test_stop();
        test_byte_write();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
